// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush arbiter: jump > irq freeze > EX busy; outputs are zero-latency, combinational from state and inputs.
// No backpressure of its own: it produces the hold/flush flags and exports a saturating count of held cycles.
module pipe_hold_ctrl #(
  parameter int AddrWidth   = 32,
  parameter int FlushCycles = 1,
  parameter int CntWidth    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 jump_flag_i,
  input  logic [AddrWidth-1:0] jump_addr_i,
  input  logic                 ex_hold_i,
  input  logic                 irq_hold_i,
  output logic                 hold_pc_o,
  output logic                 flush_if_id_o,
  output logic                 flush_id_ex_o,
  output logic                 jump_flag_o,
  output logic [AddrWidth-1:0] jump_addr_o,
  output logic [CntWidth-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam logic [3:0] FcntLoad   = 4'(FlushCycles - 1);
  localparam bit         MultiFlush = (FlushCycles > 1);

  state_t     state, state_n;
  logic [3:0] fcnt, fcnt_n;
  logic       stall_req;
  logic       any_hold;

  assign stall_req = irq_hold_i | ex_hold_i;
  assign any_hold  = hold_pc_o | flush_if_id_o | flush_id_ex_o;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= RUN;
      fcnt        <= 4'd0;
      stall_cnt_o <= '0;
    end else begin
      state <= state_n;
      fcnt  <= fcnt_n;
      if (any_hold && (stall_cnt_o != {CntWidth{1'b1}})) begin
        stall_cnt_o <= stall_cnt_o + 1'b1;
      end
    end
  end

  always_comb begin
    state_n       = state;
    fcnt_n        = fcnt;
    hold_pc_o     = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    jump_flag_o   = 1'b0;
    jump_addr_o   = '0;

    if (!rst) begin
      state_n = RUN;
      fcnt_n  = 4'd0;
    end else if (jump_flag_i) begin
      // A redirect wins from every state and restarts the bubble window.
      jump_flag_o   = 1'b1;
      jump_addr_o   = jump_addr_i;
      flush_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
      if (MultiFlush) begin
        state_n = FLUSH;
        fcnt_n  = FcntLoad;
      end else begin
        state_n = RUN;
        fcnt_n  = 4'd0;
      end
    end else begin
      case (state)
        RUN: begin
          if (stall_req) begin
            hold_pc_o     = 1'b1;
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
            state_n       = STALL;
          end
        end
        FLUSH: begin
          flush_if_id_o = 1'b1;
          flush_id_ex_o = 1'b1;
          fcnt_n        = fcnt - 4'd1;
          if (fcnt == 4'd1) begin
            state_n = RUN;
          end
        end
        STALL: begin
          // Release is immediate: the cycle the request drops is already unheld.
          if (stall_req) begin
            hold_pc_o     = 1'b1;
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
          end else begin
            state_n = RUN;
          end
        end
        default: begin
          state_n = RUN;
          fcnt_n  = 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Drives three controller instances (1, 2 and 3 flush cycles; the first with a 3-bit counter) from shared inputs.
module tb_pipe_hold_ctrl;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          jump_flag_i;
  logic [AW-1:0] jump_addr_i;
  logic          ex_hold_i;
  logic          irq_hold_i;

  logic          hold_pc     [3];
  logic          flush_if_id [3];
  logic          flush_id_ex [3];
  logic          jump_flag   [3];
  logic [AW-1:0] jump_addr   [3];
  logic [2:0]    cnt0;
  logic [31:0]   cnt1;
  logic [31:0]   cnt2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_hold_ctrl #(.AddrWidth(AW), .FlushCycles(1), .CntWidth(3)) u_fc1 (
    .clk(clk), .rst(rst), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .ex_hold_i(ex_hold_i), .irq_hold_i(irq_hold_i), .hold_pc_o(hold_pc[0]),
    .flush_if_id_o(flush_if_id[0]), .flush_id_ex_o(flush_id_ex[0]),
    .jump_flag_o(jump_flag[0]), .jump_addr_o(jump_addr[0]), .stall_cnt_o(cnt0)
  );

  pipe_hold_ctrl #(.AddrWidth(AW), .FlushCycles(2), .CntWidth(32)) u_fc2 (
    .clk(clk), .rst(rst), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .ex_hold_i(ex_hold_i), .irq_hold_i(irq_hold_i), .hold_pc_o(hold_pc[1]),
    .flush_if_id_o(flush_if_id[1]), .flush_id_ex_o(flush_id_ex[1]),
    .jump_flag_o(jump_flag[1]), .jump_addr_o(jump_addr[1]), .stall_cnt_o(cnt1)
  );

  pipe_hold_ctrl #(.AddrWidth(AW), .FlushCycles(3), .CntWidth(32)) u_fc3 (
    .clk(clk), .rst(rst), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .ex_hold_i(ex_hold_i), .irq_hold_i(irq_hold_i), .hold_pc_o(hold_pc[2]),
    .flush_if_id_o(flush_if_id[2]), .flush_id_ex_o(flush_id_ex[2]),
    .jump_flag_o(jump_flag[2]), .jump_addr_o(jump_addr[2]), .stall_cnt_o(cnt2)
  );

  // Reference: bubbles still owed after a redirect, plus a saturating count of held cycles.
  int              flush_cycles [3] = '{1, 2, 3};
  longint unsigned cnt_max      [3] = '{64'd7, 64'hFFFF_FFFF, 64'hFFFF_FFFF};
  int              bubbles_left [3];
  longint unsigned held_cycles  [3];

  function automatic logic [63:0] cnt_of(input int k);
    case (k)
      0:       return {61'd0, cnt0};
      1:       return {32'd0, cnt1};
      default: return {32'd0, cnt2};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, check mid-cycle, then advance the model across the edge.
  task automatic step(input logic r, input logic j, input logic [AW-1:0] a,
                      input logic ex, input logic irq);
    logic e_hp, e_fl, e_j;
    logic [AW-1:0] e_a;
    rst         = r;
    jump_flag_i = j;
    jump_addr_i = a;
    ex_hold_i   = ex;
    irq_hold_i  = irq;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      e_hp = 1'b0; e_fl = 1'b0; e_j = 1'b0; e_a = '0;
      if (!r) begin
        e_hp = 1'b0;
      end else if (j) begin
        e_j = 1'b1; e_a = a; e_fl = 1'b1;
      end else if (bubbles_left[k] > 0) begin
        e_fl = 1'b1;
      end else if (ex || irq) begin
        e_hp = 1'b1; e_fl = 1'b1;
      end
      chk($sformatf("u%0d hold_pc", k),   {63'd0, hold_pc[k]},     {63'd0, e_hp});
      chk($sformatf("u%0d flush_if_id", k), {63'd0, flush_if_id[k]}, {63'd0, e_fl});
      chk($sformatf("u%0d flush_id_ex", k), {63'd0, flush_id_ex[k]}, {63'd0, e_fl});
      chk($sformatf("u%0d jump_flag", k), {63'd0, jump_flag[k]},   {63'd0, e_j});
      chk($sformatf("u%0d jump_addr", k), {32'd0, jump_addr[k]},   {32'd0, e_a});
      chk($sformatf("u%0d stall_cnt", k), cnt_of(k),               held_cycles[k]);
      if (!r) begin
        bubbles_left[k] = 0;
        held_cycles[k]  = 0;
      end else begin
        if (j) bubbles_left[k] = flush_cycles[k] - 1;
        else if (bubbles_left[k] > 0) bubbles_left[k]--;
        if ((e_hp || e_fl) && held_cycles[k] < cnt_max[k]) held_cycles[k]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
  endtask

  initial begin
    logic ex_lvl, irq_lvl;
    for (int k = 0; k < 3; k++) begin
      bubbles_left[k] = 0;
      held_cycles[k]  = 0;
    end
    rst = 1'b0; jump_flag_i = 1'b0; jump_addr_i = '0; ex_hold_i = 1'b0; irq_hold_i = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("idle cnt", {32'd0, cnt1}, 64'd0);

    // Single redirect: bubbles equal FlushCycles per instance.
    step(1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("jump fc1 cnt", {61'd0, cnt0}, 64'd1);
    chk("jump fc2 cnt", {32'd0, cnt1}, 64'd2);
    chk("jump fc3 cnt", {32'd0, cnt2}, 64'd3);

    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("ex_hold 4 cnt", {32'd0, cnt1}, 64'd4);

    // Jump and EX busy together: the redirect only, then the stall.
    do_reset();
    step(1'b1, 1'b1, 32'h0000_0040, 1'b1, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("jump+ex fc1 cnt", {61'd0, cnt0}, 64'd3);

    do_reset();
    step(1'b1, 1'b1, 32'h0000_0200, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0300, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("b2b fc3 cnt", {32'd0, cnt2}, 64'd4);

    // Saturation of the 3-bit counter, then reset in the middle of a stall.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    chk("sat cnt", {61'd0, cnt0}, 64'd7);
    chk("no sat wide cnt", {32'd0, cnt1}, 64'd10);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("reset mid-stall cnt", {61'd0, cnt0}, 64'd0);

    ex_lvl = 1'b0;
    irq_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) ex_lvl = ~ex_lvl;
      if ($urandom_range(0, 9) == 0) irq_lvl = ~irq_lvl;
      step($urandom_range(0, 199) != 0, $urandom_range(0, 6) == 0, $urandom,
           ex_lvl, irq_lvl);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
